// File: rtl/stim_seq_pkg.sv
// -----------------------------------------------------------------------------
// stim_seq_pkg
// Shared types for the stimulus sequencer: playback mode encoding, engine
// state encoding and the loop-counter width.
// -----------------------------------------------------------------------------
package stim_seq_pkg;

    // Playback mode as presented on the mode input. RSVD plays like ONESHOT.
    typedef enum logic [1:0] {
        M_ONESHOT = 2'd0,
        M_LOOP    = 2'd1,
        M_STEP    = 2'd2,
        M_RSVD    = 2'd3
    } mode_e;

    // Engine state.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int LOOP_CNT_W = 16;

endpackage

// File: rtl/stim_seq_mem.sv
// -----------------------------------------------------------------------------
// stim_seq_mem
// DEPTH x VEC_W vector store: one write port, one synchronous read port.
// No reset on the array or on the read register; contents survive reset.
//
// Ports:
//   clock    in   system clock
//   wr_en    in   write strobe (already qualified by the caller)
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data updates only when set
//   rd_addr  in   read address
//   rd_data  out  registered read data
// -----------------------------------------------------------------------------
module stim_seq_mem #(
    parameter int VEC_W = 2,
    parameter int DEPTH = 10,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [VEC_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [VEC_W-1:0] rd_data
);

    logic [VEC_W-1:0] r_mem [DEPTH];
    logic [VEC_W-1:0] r_rd_data;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/stim_sequencer.sv
// -----------------------------------------------------------------------------
// stim_sequencer
// Loadable stimulus player. The harness controller fills the vector memory
// while the engine is idle, then issues go/halt/step; the engine replays the
// vectors onto the DUT inputs in one-shot, loop or single-step mode.
//
// Ports:
//   clock      in   system clock, all state on rising edge
//   reset      in   asynchronous active-low reset
//   wr_en      in   write one vector entry
//   wr_addr    in   entry address
//   wr_data    in   entry data
//   wr_err     out  one-cycle pulse when a write is rejected
//   go         in   start playback (mode and len sampled with it)
//   halt       in   abort playback, highest priority
//   step       in   advance one vector in step mode
//   mode       in   0=ONESHOT 1=LOOP 2=STEP 3=reserved(ONESHOT)
//   len        in   number of entries to play (clamped to DEPTH)
//   vec_out    out  stimulus vector
//   vec_valid  out  vec_out was refreshed from memory this cycle
//   busy       out  engine in RUN or STEP
//   done       out  playback finished (level)
//   pc         out  index of the next entry to read
//   loop_cnt   out  completed LOOP passes, saturating
// -----------------------------------------------------------------------------
module stim_sequencer
    import stim_seq_pkg::*;
#(
    parameter int               VEC_W     = 2,
    parameter int               DEPTH     = 10,
    parameter logic [VEC_W-1:0] RESET_VEC = {VEC_W{1'b0}},
    localparam int              AW        = $clog2(DEPTH),
    localparam int              CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [VEC_W-1:0]      wr_data,
    output logic                  wr_err,
    input  logic                  go,
    input  logic                  halt,
    input  logic                  step,
    input  logic [1:0]            mode,
    input  logic [CW-1:0]         len,
    output logic [VEC_W-1:0]      vec_out,
    output logic                  vec_valid,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         pc,
    output logic [LOOP_CNT_W-1:0] loop_cnt
);

    state_e                r_state;
    mode_e                 r_mode;
    logic [CW-1:0]         r_len;
    logic [CW-1:0]         r_pc;
    logic [LOOP_CNT_W-1:0] r_loop_cnt;
    logic                  r_valid;
    logic                  r_done;
    logic                  r_wr_err;
    // Set on the first memory read after reset. Until then the read register
    // holds garbage (it has no reset), so vec_out shows RESET_VEC instead.
    logic                  r_loaded;

    logic                  w_idle_like;
    logic                  w_wr_ok;
    logic                  w_emit;
    logic                  w_last;
    logic [CW-1:0]         w_eff_len;
    logic [AW-1:0]         w_rd_addr;
    logic [VEC_W-1:0]      w_rd_data;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_wr_ok     = wr_en && w_idle_like && (32'(wr_addr) < DEPTH);
    assign w_eff_len   = (32'(len) > DEPTH) ? CW'(DEPTH) : len;
    assign w_last      = (r_pc == r_len - CW'(1));

    // A memory read happens on every RUN edge and on STEP edges with step,
    // unless halt cancels it.
    assign w_emit = !halt && ((r_state == S_RUN) || (r_state == S_STEP && step));

    // pc never reaches DEPTH while reading, so the low AW bits are the index.
    assign w_rd_addr = r_pc[AW-1:0];

    stim_seq_mem #(
        .VEC_W (VEC_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock   (clock),
        .wr_en   (w_wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (w_emit),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_mode     <= M_ONESHOT;
            r_len      <= '0;
            r_pc       <= '0;
            r_loop_cnt <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_wr_err   <= 1'b0;
            r_loaded   <= 1'b0;
        end else begin
            r_wr_err <= wr_en && !w_wr_ok;
            r_valid  <= w_emit;
            if (w_emit) begin
                r_loaded <= 1'b1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (halt) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end else if (go) begin
                        r_mode     <= mode_e'(mode);
                        r_len      <= w_eff_len;
                        r_pc       <= '0;
                        r_loop_cnt <= '0;
                        r_done     <= 1'b0;
                        if (w_eff_len == '0) begin
                            r_state <= S_DONE;
                        end else if (mode_e'(mode) == M_STEP) begin
                            r_state <= S_STEP;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else begin
                        // done follows DONE by one edge, so it rises the
                        // cycle after the last vector's vec_valid.
                        r_done <= (r_state == S_DONE);
                    end
                end

                S_RUN: begin
                    if (halt) begin
                        r_state <= S_IDLE;
                    end else if (w_last) begin
                        if (r_mode == M_LOOP) begin
                            // Wrap with no bubble: mem[0] is read next edge.
                            r_pc <= '0;
                            if (r_loop_cnt != {LOOP_CNT_W{1'b1}}) begin
                                r_loop_cnt <= r_loop_cnt + LOOP_CNT_W'(1);
                            end
                        end else begin
                            r_pc    <= r_pc + CW'(1);
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_pc <= r_pc + CW'(1);
                    end
                end

                S_STEP: begin
                    if (halt) begin
                        r_state <= S_IDLE;
                    end else if (step) begin
                        r_pc <= r_pc + CW'(1);
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign vec_out   = r_loaded ? w_rd_data : RESET_VEC;
    assign vec_valid = r_valid;
    assign busy      = (r_state == S_RUN) || (r_state == S_STEP);
    assign done      = r_done;
    assign pc        = r_pc;
    assign loop_cnt  = r_loop_cnt;
    assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_stim_sequencer.sv
module tb_stim_sequencer;

    logic        clock;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [1:0]  wr_data;
    logic        wr_err;
    logic        go;
    logic        halt;
    logic        step;
    logic [1:0]  mode;
    logic [3:0]  len;
    logic [1:0]  vec_out;
    logic        vec_valid;
    logic        busy;
    logic        done;
    logic [3:0]  pc;
    logic [15:0] loop_cnt;

    int n_pass  = 0;
    int n_total = 0;

    logic [1:0] pat [10];

    stim_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_err    (wr_err),
        .go        (go),
        .halt      (halt),
        .step      (step),
        .mode      (mode),
        .len       (len),
        .vec_out   (vec_out),
        .vec_valid (vec_valid),
        .busy      (busy),
        .done      (done),
        .pc        (pc),
        .loop_cnt  (loop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start(input logic [1:0] m, input logic [3:0] l);
        go = 1'b1; mode = m; len = l;
        tick();
        go = 1'b0;
    endtask

    initial begin
        pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b11; pat[3] = 2'b00;
        pat[4] = 2'b10; pat[5] = 2'b01; pat[6] = 2'b11; pat[7] = 2'b11;
        pat[8] = 2'b01; pat[9] = 2'b10;

        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        go = 1'b0; halt = 1'b0; step = 1'b0; mode = '0; len = '0;

        // Reset state
        #3;
        chk("rst_vec", 32'(vec_out), 0);
        chk("rst_valid", 32'(vec_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_loop", 32'(loop_cnt), 0);
        chk("rst_wrerr", 32'(wr_err), 0);
        #4 reset = 1'b1;
        tick();

        // Load all entries
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = pat[i];
            tick();
            chk("load_wrerr", 32'(wr_err), 0);
        end
        wr_en = 1'b0;

        // ONESHOT len=4
        start(2'd0, 4'd4);
        chk("os_busy_E", 32'(busy), 1);
        chk("os_valid_E", 32'(vec_valid), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("os_vec", 32'(vec_out), 32'(pat[k]));
            chk("os_valid", 32'(vec_valid), 1);
            chk("os_done_early", 32'(done), 0);
        end
        tick();
        chk("os_done", 32'(done), 1);
        chk("os_valid_end", 32'(vec_valid), 0);
        chk("os_pc", 32'(pc), 4);
        chk("os_hold", 32'(vec_out), 32'(pat[3]));
        chk("os_busy_end", 32'(busy), 0);

        // LOOP len=3, halt after 10 vectors
        start(2'd1, 4'd3);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("lp_vec", 32'(vec_out), 32'(pat[k % 3]));
            chk("lp_valid", 32'(vec_valid), 1);
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("lp_loopcnt", 32'(loop_cnt), 3);
        chk("lp_busy", 32'(busy), 0);
        chk("lp_valid_halt", 32'(vec_valid), 0);
        chk("lp_done", 32'(done), 0);
        chk("lp_hold", 32'(vec_out), 32'(pat[0]));
        chk("lp_pc", 32'(pc), 1);
        tick();
        chk("lp_idle_valid", 32'(vec_valid), 0);

        // STEP len=2
        start(2'd2, 4'd2);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("st_wait_valid", 32'(vec_valid), 0);
            chk("st_wait_busy", 32'(busy), 1);
        end
        step = 1'b1; tick(); step = 1'b0;
        chk("st_vec1", 32'(vec_out), 32'(pat[0]));
        chk("st_valid1", 32'(vec_valid), 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("st_gap_valid", 32'(vec_valid), 0);
            chk("st_gap_hold", 32'(vec_out), 32'(pat[0]));
        end
        step = 1'b1; tick(); step = 1'b0;
        chk("st_vec2", 32'(vec_out), 32'(pat[1]));
        chk("st_valid2", 32'(vec_valid), 1);
        chk("st_busy2", 32'(busy), 0);
        tick();
        chk("st_done", 32'(done), 1);
        chk("st_valid_end", 32'(vec_valid), 0);
        chk("st_hold", 32'(vec_out), 32'(pat[1]));

        // len=0
        start(2'd0, 4'd0);
        chk("l0_valid", 32'(vec_valid), 0);
        chk("l0_busy", 32'(busy), 0);
        chk("l0_done_clr", 32'(done), 0);
        tick();
        chk("l0_done", 32'(done), 1);
        chk("l0_valid2", 32'(vec_valid), 0);
        chk("l0_hold", 32'(vec_out), 32'(pat[1]));

        // len=15 clamps to 10
        start(2'd0, 4'd15);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("l15_vec", 32'(vec_out), 32'(pat[k]));
            chk("l15_valid", 32'(vec_valid), 1);
        end
        tick();
        chk("l15_done", 32'(done), 1);
        chk("l15_pc", 32'(pc), 10);
        chk("l15_valid_end", 32'(vec_valid), 0);

        // Write while busy is rejected
        start(2'd1, 4'd4);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 2'b11;
        tick();
        wr_en = 1'b0;
        chk("wb_err", 32'(wr_err), 1);
        tick();
        chk("wb_err_clr", 32'(wr_err), 0);
        halt = 1'b1; tick(); halt = 1'b0;
        chk("wb_idle", 32'(busy), 0);

        // Out-of-range address in IDLE is rejected
        wr_en = 1'b1; wr_addr = 4'd12; wr_data = 2'b00;
        tick();
        wr_en = 1'b0;
        chk("oor_err", 32'(wr_err), 1);
        tick();
        chk("oor_err_clr", 32'(wr_err), 0);

        // Readback: memory unchanged
        start(2'd0, 4'd4);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rb_vec", 32'(vec_out), 32'(pat[k]));
        end
        tick();

        // Asynchronous reset mid-RUN
        start(2'd1, 4'd3);
        tick(); tick();
        chk("ar_busy_pre", 32'(busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_vec", 32'(vec_out), 0);
        chk("ar_valid", 32'(vec_valid), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_pc", 32'(pc), 0);
        chk("ar_loop", 32'(loop_cnt), 0);
        chk("ar_done", 32'(done), 0);
        reset = 1'b1;
        tick();

        // go + halt together in DONE
        start(2'd0, 4'd1);
        tick();
        chk("gh_vec", 32'(vec_out), 32'(pat[0]));
        tick();
        chk("gh_done_pre", 32'(done), 1);
        go = 1'b1; halt = 1'b1; mode = 2'd0; len = 4'd4;
        tick();
        go = 1'b0; halt = 1'b0;
        chk("gh_busy", 32'(busy), 0);
        chk("gh_done", 32'(done), 0);
        chk("gh_valid", 32'(vec_valid), 0);
        tick();
        chk("gh_busy2", 32'(busy), 0);
        chk("gh_valid2", 32'(vec_valid), 0);
        chk("gh_hold", 32'(vec_out), 32'(pat[0]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stim_sequencer.md
Name: stim_sequencer

Overview:
Synthesizable, parametrised stimulus player for concolic/RL test harnesses. Replaces the fixed-width, fixed-depth testbench opcode driver with a loadable vector memory and a controlled run engine. The engine replays vectors onto DUT inputs in one-shot, loop or single-step mode. It sits between the harness controller, which loads vectors and issues go/halt/step, and the DUT input pins.

Parameters:
VEC_W, 2, width of each stimulus vector (bit 0 drives start, bit 1 drives __obs in the b07 harness)
DEPTH, 10, number of vector entries
AW, $clog2(DEPTH), write address width (derived, not overridden)
CW, $clog2(DEPTH+1), length and pc width (derived)
RESET_VEC, {VEC_W{1'b0}}, vec_out value after reset

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
wr_en  in  1  write one vector entry
wr_addr  in  AW  entry address
wr_data  in  VEC_W  entry data
wr_err  out  1  one-cycle pulse when a write is rejected
go  in  1  start playback; sampled with mode and len
halt  in  1  abort playback
step  in  1  advance one vector in step mode
mode  in  2  0=ONESHOT, 1=LOOP, 2=STEP, 3=reserved (treated as ONESHOT)
len  in  CW  number of entries to play
vec_out  out  VEC_W  registered stimulus vector
vec_valid  out  1  vec_out was updated from memory this cycle
busy  out  1  engine in RUN or STEP
done  out  1  playback finished (level)
pc  out  CW  index of the next entry to read
loop_cnt  out  16  completed LOOP passes, saturating at 16'hFFFF

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; vec_out=RESET_VEC; vec_valid=0; busy=0; done=0; pc=0; loop_cnt=0; wr_err=0. Memory contents are not reset.
- States: IDLE, RUN, STEP, DONE.
- Start: go sampled high at edge E in IDLE or DONE:
  - latch mode and eff_len=min(len,DEPTH); clear pc, loop_cnt and done.
  - eff_len==0: go straight to DONE; no vector is emitted.
  - otherwise: next state is RUN (modes 0/1/3) or STEP (mode 2).
  - go is ignored while busy.
- RUN:
  - on every edge, vec_out<=mem[pc], vec_valid<=1, pc<=pc+1.
  - First vector appears at edge E+1, then one vector per cycle.
- End of pass (the read with pc==eff_len-1):
  - ONESHOT: next state DONE, pc=eff_len.
  - LOOP: pc wraps to 0 and loop_cnt increments (saturating). There is no bubble: mem[0] follows mem[eff_len-1] on the next edge.
- STEP: each cycle with step=1 emits mem[pc] (vec_valid pulses once) and increments pc. After the last entry, next state is DONE. Cycles without step leave vec_out held and vec_valid=0.
- DONE: done=1, vec_valid=0, vec_out holds the last vector.
- halt: from RUN, STEP or DONE, go to IDLE on the next edge. vec_valid=0, done=0, vec_out holds its value, pc and loop_cnt hold.
  - halt has priority over go, step and end-of-pass when asserted in the same cycle.
- Writes: accepted only in IDLE or DONE with wr_addr<DEPTH, and take effect on the next edge. A write while busy or with an out-of-range address is dropped and pulses wr_err high for one cycle.
- Read port is synchronous (1-cycle). A write to the entry being read in the same cycle is impossible, because writes are blocked while busy.
- busy = (state==RUN || state==STEP), taken from registered state.

Decomposition:
- Package stim_seq_pkg holds:
  - mode_e: ONESHOT=0, LOOP=1, STEP=2, RSVD=3.
  - state_e: IDLE, RUN, STEP, DONE.
  - LOOP_CNT_W=16.
- Sub-module stim_seq_mem: DEPTH x VEC_W register array with 1 write port and 1 synchronous read port, no reset.
- The top level holds the FSM, pc, loop counter and output registers.

Test Plan:
- Load entries 0..3 = 01,10,11,00; go with mode=0, len=4 -> vec_out 01,10,11,00 at edges E+1..E+4, vec_valid high 4 cycles, done=1 from E+5, pc=4.
- Same data, mode=1, len=3; halt after 10 valid cycles -> sequence 01,10,11 repeats with no gap, loop_cnt=3, state IDLE, busy=0, vec_out held.
- mode=2, len=2; step pulses at cycles 3 and 7 -> exactly 2 vec_valid pulses (01 then 10), done after the second pulse, vec_out=10 held.
- len=0 and len=15 (DEPTH=10): len=0 -> done immediately, no vec_valid. len=15 -> 10 vectors played, pc=10.
- wr_en during RUN, and wr_addr=12 in IDLE -> wr_err pulses 1 cycle each, memory unchanged on readback.
- reset driven low mid-RUN between edges -> outputs at reset values immediately; go+halt in the same cycle in DONE -> IDLE, no playback.
